// File: rtl/traffic_signal_monitor.sv
// traffic_signal_monitor
//
// Independent receiver and conflict monitor for the 2-bit lamp codes coming
// from the traffic light controller. Decodes each direction's code into a
// one-hot lamp drive, checks every sample against the signalling protocol
// and, on a violation, latches the first fault cause and flashes both
// directions red until an operator clear.
//
// Codes: 00 green, 01 yellow, 11 red, 10 illegal.
//
// Ports
//   clk            system clock, rising edge
//   rst_n          synchronous active-low reset
//   highway_light  highway code from the controller
//   farm_light     farm road code from the controller
//   fault_clear    operator clear, only acted on while faulted
//   highway_lamps  {red, yellow, green} highway lamp drive (registered)
//   farm_lamps     {red, yellow, green} farm lamp drive (registered)
//   fault          high while faulted (registered)
//   fault_code     first fault cause: 0 none, 1 conflict, 2 illegal code,
//                  3 illegal transition, 4 short yellow (registered)
module traffic_signal_monitor #(
    parameter int MIN_YELLOW = 20,
    parameter int FLASH_HALF = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] highway_light,
    input  logic [1:0] farm_light,
    input  logic       fault_clear,
    output logic [2:0] highway_lamps,
    output logic [2:0] farm_lamps,
    output logic       fault,
    output logic [2:0] fault_code
);

    localparam int YW = $clog2(MIN_YELLOW + 1);
    localparam int FW = $clog2(2 * FLASH_HALF);

    localparam logic [YW-1:0] Y_MIN  = YW'(MIN_YELLOW);
    localparam logic [FW-1:0] F_HALF = FW'(FLASH_HALF);
    localparam logic [FW-1:0] F_LAST = FW'(2 * FLASH_HALF - 1);

    localparam logic [1:0] C_GREEN   = 2'b00;
    localparam logic [1:0] C_YELLOW  = 2'b01;
    localparam logic [1:0] C_ILLEGAL = 2'b10;
    localparam logic [1:0] C_RED     = 2'b11;

    localparam logic [2:0] LAMP_RED = 3'b100;
    localparam logic [2:0] LAMP_OFF = 3'b000;

    localparam logic [2:0] FC_NONE     = 3'd0;
    localparam logic [2:0] FC_CONFLICT = 3'd1;
    localparam logic [2:0] FC_ILLEGAL  = 3'd2;
    localparam logic [2:0] FC_TRANS    = 3'd3;
    localparam logic [2:0] FC_SHORT    = 3'd4;

    typedef enum logic [1:0] {
        S_INIT,
        S_RUN,
        S_FAULT
    } state_t;

    state_t        state;
    logic          armed;      // low for the first edge after reset release
    logic [1:0]    hw_prev;
    logic [1:0]    fm_prev;
    logic [YW-1:0] hw_ycnt;
    logic [YW-1:0] fm_ycnt;
    logic [FW-1:0] flash_cnt;  // phase of the next FAULT cycle
    logic [2:0]    chk_code;

    function automatic logic [2:0] decode(input logic [1:0] code);
        case (code)
            C_GREEN:  decode = 3'b001;
            C_YELLOW: decode = 3'b010;
            default:  decode = 3'b100;
        endcase
    endfunction

    function automatic logic legal_step(input logic [1:0] prev, input logic [1:0] cur);
        legal_step = (prev == cur)
                  || (prev == C_GREEN  && cur == C_YELLOW)
                  || (prev == C_YELLOW && cur == C_RED)
                  || (prev == C_RED    && cur == C_GREEN);
    endfunction

    function automatic logic short_yellow(input logic [1:0] prev, input logic [1:0] cur,
                                          input logic [YW-1:0] cnt);
        short_yellow = (prev == C_YELLOW) && (cur == C_RED) && (cnt < Y_MIN);
    endfunction

    // Saturating count of consecutive yellow samples, including the current one.
    function automatic logic [YW-1:0] ycnt_next(input logic [1:0] cur, input logic [YW-1:0] cnt);
        if (cur != C_YELLOW)
            ycnt_next = '0;
        else if (cnt >= Y_MIN)
            ycnt_next = Y_MIN;
        else
            ycnt_next = cnt + 1'b1;
    endfunction

    // Fault classification of the current sample; lowest code wins.
    // Transition and yellow-length checks need a previous sample, so only RUN does them.
    always_comb begin
        chk_code = FC_NONE;
        if (highway_light != C_RED && farm_light != C_RED)
            chk_code = FC_CONFLICT;
        else if (highway_light == C_ILLEGAL || farm_light == C_ILLEGAL)
            chk_code = FC_ILLEGAL;
        else if (state == S_RUN) begin
            if (!legal_step(hw_prev, highway_light) || !legal_step(fm_prev, farm_light))
                chk_code = FC_TRANS;
            else if (short_yellow(hw_prev, highway_light, hw_ycnt) ||
                     short_yellow(fm_prev, farm_light, fm_ycnt))
                chk_code = FC_SHORT;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state         <= S_INIT;
            armed         <= 1'b0;
            hw_prev       <= C_RED;
            fm_prev       <= C_RED;
            hw_ycnt       <= '0;
            fm_ycnt       <= '0;
            flash_cnt     <= '0;
            highway_lamps <= LAMP_RED;
            farm_lamps    <= LAMP_RED;
            fault         <= 1'b0;
            fault_code    <= FC_NONE;
        end else begin
            armed <= 1'b1;
            case (state)
                S_INIT, S_RUN: begin
                    // The edge that first sees rst_n high still behaves as reset.
                    if (state == S_RUN || armed) begin
                        if (chk_code != FC_NONE) begin
                            // Offending code is never shown; flash starts in its "on" half.
                            state         <= S_FAULT;
                            fault         <= 1'b1;
                            fault_code    <= chk_code;
                            highway_lamps <= LAMP_RED;
                            farm_lamps    <= LAMP_RED;
                            flash_cnt     <= FW'(1);
                        end else begin
                            state         <= S_RUN;
                            hw_prev       <= highway_light;
                            fm_prev       <= farm_light;
                            hw_ycnt       <= ycnt_next(highway_light, (state == S_INIT) ? '0 : hw_ycnt);
                            fm_ycnt       <= ycnt_next(farm_light, (state == S_INIT) ? '0 : fm_ycnt);
                            highway_lamps <= decode(highway_light);
                            farm_lamps    <= decode(farm_light);
                        end
                    end
                end
                S_FAULT: begin
                    if (fault_clear) begin
                        state         <= S_INIT;
                        fault         <= 1'b0;
                        fault_code    <= FC_NONE;
                        highway_lamps <= LAMP_RED;
                        farm_lamps    <= LAMP_RED;
                        flash_cnt     <= '0;
                        hw_ycnt       <= '0;
                        fm_ycnt       <= '0;
                    end else begin
                        highway_lamps <= (flash_cnt < F_HALF) ? LAMP_RED : LAMP_OFF;
                        farm_lamps    <= (flash_cnt < F_HALF) ? LAMP_RED : LAMP_OFF;
                        flash_cnt     <= (flash_cnt == F_LAST) ? '0 : flash_cnt + 1'b1;
                    end
                end
                default: state <= S_INIT;
            endcase
        end
    end

endmodule

// File: tb/tb_traffic_signal_monitor.sv
`timescale 1ns/1ps
module tb_traffic_signal_monitor;

    localparam int MIN_YELLOW = 4;
    localparam int FLASH_HALF = 8;

    localparam logic [2:0] R   = 3'b100;
    localparam logic [2:0] Y   = 3'b010;
    localparam logic [2:0] G   = 3'b001;
    localparam logic [2:0] OFF = 3'b000;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       fault_clear;
    logic [1:0] highway_light;
    logic [1:0] farm_light;
    logic [2:0] highway_lamps;
    logic [2:0] farm_lamps;
    logic       fault;
    logic [2:0] fault_code;

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic [1:0] hw;
        logic [1:0] fm;
        logic       clr;
        logic       rn;
        logic [9:0] exp;
    } stim_t;

    stim_t      plan[$];
    logic [9:0] sb[$];

    traffic_signal_monitor #(
        .MIN_YELLOW(MIN_YELLOW),
        .FLASH_HALF(FLASH_HALF)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .highway_light(highway_light),
        .farm_light   (farm_light),
        .fault_clear  (fault_clear),
        .highway_lamps(highway_lamps),
        .farm_lamps   (farm_lamps),
        .fault        (fault),
        .fault_code   (fault_code)
    );

    always #5 clk = ~clk;

    function automatic logic [2:0] dec(input logic [1:0] c);
        case (c)
            2'b00:   return G;
            2'b01:   return Y;
            default: return R;
        endcase
    endfunction

    function automatic logic [9:0] ew(input logic [2:0] hl, input logic [2:0] fl,
                                      input logic f, input logic [2:0] c);
        return {hl, fl, f, c};
    endfunction

    task automatic add(input logic [1:0] hw, input logic [1:0] fm, input logic clr,
                       input logic rn, input logic [9:0] e);
        stim_t s;
        s.hw = hw; s.fm = fm; s.clr = clr; s.rn = rn; s.exp = e;
        plan.push_back(s);
    endtask

    task automatic add_norm(input logic [1:0] hw, input logic [1:0] fm, input int n);
        for (int i = 0; i < n; i++) add(hw, fm, 1'b0, 1'b1, ew(dec(hw), dec(fm), 1'b0, 3'd0));
    endtask

    // One reset cycle then two all-red cycles; leaves the monitor sampling with prev = red/red.
    task automatic add_restart();
        add(2'b11, 2'b11, 1'b0, 1'b0, ew(R, R, 1'b0, 3'd0));
        add(2'b11, 2'b11, 1'b0, 1'b1, ew(R, R, 1'b0, 3'd0));
        add(2'b11, 2'b11, 1'b0, 1'b1, ew(R, R, 1'b0, 3'd0));
    endtask

    // Fault cycles first..last counted from the fault entry edge (entry = 0); inputs random.
    task automatic add_flash(input logic [2:0] code, input int first, input int last);
        for (int i = first; i <= last; i++) begin
            logic [2:0] l;
            l = ((i % (2 * FLASH_HALF)) < FLASH_HALF) ? R : OFF;
            add(2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)), 1'b0, 1'b1,
                ew(l, l, 1'b1, code));
        end
    endtask

    task automatic drive_step(input stim_t s);
        highway_light = s.hw;
        farm_light    = s.fm;
        fault_clear   = s.clr;
        rst_n         = s.rn;
        sb.push_back(s.exp);
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        plan.delete();
        add(2'b11, 2'b11, 1'b0, 1'b0, ew(R, R, 1'b0, 3'd0));
        add(2'b11, 2'b11, 1'b0, 1'b0, ew(R, R, 1'b0, 3'd0));
        add(2'b10, 2'b00, 1'b1, 1'b0, ew(R, R, 1'b0, 3'd0));
        add(2'b11, 2'b11, 1'b0, 1'b1, ew(R, R, 1'b0, 3'd0));
        add(2'b11, 2'b11, 1'b0, 1'b1, ew(R, R, 1'b0, 3'd0));
        for (int k = 0; k < plan.size(); k++) begin
            logic [9:0] got, want;
            drive_step(plan[k]);
            want = sb.pop_front();
            got  = {highway_lamps, farm_lamps, fault, fault_code};
            checks++;
            if (got !== want) begin
                errors++;
                $display("FAIL reset[%0d]: got lamps=%b/%b fault=%b code=%0d, want lamps=%b/%b fault=%b code=%0d",
                         k, got[9:7], got[6:4], got[3], got[2:0], want[9:7], want[6:4], want[3], want[2:0]);
            end
        end
    endtask

    task automatic test_normal();
        plan.delete();
        add_norm(2'b00, 2'b11, 30);
        add_norm(2'b01, 2'b11, 21);
        add_norm(2'b11, 2'b00, 10);
        add_norm(2'b11, 2'b01, 21);
        add_norm(2'b00, 2'b11, 5);
        for (int k = 0; k < plan.size(); k++) begin
            logic [9:0] got, want;
            drive_step(plan[k]);
            want = sb.pop_front();
            got  = {highway_lamps, farm_lamps, fault, fault_code};
            checks++;
            if (got !== want) begin
                errors++;
                $display("FAIL normal[%0d]: got lamps=%b/%b fault=%b code=%0d, want lamps=%b/%b fault=%b code=%0d",
                         k, got[9:7], got[6:4], got[3], got[2:0], want[9:7], want[6:4], want[3], want[2:0]);
            end
        end
    endtask

    task automatic test_conflict();
        plan.delete();
        add_restart();
        add_norm(2'b00, 2'b11, 3);
        add(2'b00, 2'b00, 1'b0, 1'b1, ew(R, R, 1'b1, 3'd1));
        add_flash(3'd1, 1, 31);
        for (int k = 0; k < plan.size(); k++) begin
            logic [9:0] got, want;
            drive_step(plan[k]);
            want = sb.pop_front();
            got  = {highway_lamps, farm_lamps, fault, fault_code};
            checks++;
            if (got !== want) begin
                errors++;
                $display("FAIL conflict[%0d]: got lamps=%b/%b fault=%b code=%0d, want lamps=%b/%b fault=%b code=%0d",
                         k, got[9:7], got[6:4], got[3], got[2:0], want[9:7], want[6:4], want[3], want[2:0]);
            end
        end
    endtask

    task automatic test_illegal();
        plan.delete();
        // green -> red skipping yellow
        add_restart();
        add_norm(2'b00, 2'b11, 2);
        add(2'b11, 2'b11, 1'b0, 1'b1, ew(R, R, 1'b1, 3'd3));
        add_flash(3'd3, 1, 2);
        // illegal code on highway
        add_restart();
        add_norm(2'b00, 2'b11, 2);
        add(2'b10, 2'b11, 1'b0, 1'b1, ew(R, R, 1'b1, 3'd2));
        add_flash(3'd2, 1, 2);
        // illegal code together with conflict: conflict wins
        add_restart();
        add_norm(2'b00, 2'b11, 2);
        add(2'b10, 2'b00, 1'b0, 1'b1, ew(R, R, 1'b1, 3'd1));
        add_flash(3'd1, 1, 2);
        // yellow -> green
        add_restart();
        add_norm(2'b00, 2'b11, 2);
        add_norm(2'b01, 2'b11, 5);
        add(2'b00, 2'b11, 1'b0, 1'b1, ew(R, R, 1'b1, 3'd3));
        add_flash(3'd3, 1, 2);
        // farm red -> yellow
        add_restart();
        add(2'b11, 2'b01, 1'b0, 1'b1, ew(R, R, 1'b1, 3'd3));
        add_flash(3'd3, 1, 2);
        for (int k = 0; k < plan.size(); k++) begin
            logic [9:0] got, want;
            drive_step(plan[k]);
            want = sb.pop_front();
            got  = {highway_lamps, farm_lamps, fault, fault_code};
            checks++;
            if (got !== want) begin
                errors++;
                $display("FAIL illegal[%0d]: got lamps=%b/%b fault=%b code=%0d, want lamps=%b/%b fault=%b code=%0d",
                         k, got[9:7], got[6:4], got[3], got[2:0], want[9:7], want[6:4], want[3], want[2:0]);
            end
        end
    endtask

    task automatic test_short_yellow();
        plan.delete();
        // highway yellow one short
        add_restart();
        add_norm(2'b00, 2'b11, 2);
        add_norm(2'b01, 2'b11, MIN_YELLOW - 1);
        add(2'b11, 2'b11, 1'b0, 1'b1, ew(R, R, 1'b1, 3'd4));
        add_flash(3'd4, 1, 2);
        // highway yellow exactly long enough, then a long saturating farm yellow
        add_restart();
        add_norm(2'b00, 2'b11, 2);
        add_norm(2'b01, 2'b11, MIN_YELLOW);
        add_norm(2'b11, 2'b11, 1);
        add_norm(2'b11, 2'b00, 2);
        add_norm(2'b11, 2'b01, 2 * MIN_YELLOW);
        add_norm(2'b11, 2'b11, 2);
        add_norm(2'b00, 2'b11, 2);
        // farm yellow too short
        add_restart();
        add_norm(2'b11, 2'b00, 2);
        add_norm(2'b11, 2'b01, 2);
        add(2'b11, 2'b11, 1'b0, 1'b1, ew(R, R, 1'b1, 3'd4));
        add_flash(3'd4, 1, 1);
        for (int k = 0; k < plan.size(); k++) begin
            logic [9:0] got, want;
            drive_step(plan[k]);
            want = sb.pop_front();
            got  = {highway_lamps, farm_lamps, fault, fault_code};
            checks++;
            if (got !== want) begin
                errors++;
                $display("FAIL short_yellow[%0d]: got lamps=%b/%b fault=%b code=%0d, want lamps=%b/%b fault=%b code=%0d",
                         k, got[9:7], got[6:4], got[3], got[2:0], want[9:7], want[6:4], want[3], want[2:0]);
            end
        end
    endtask

    task automatic test_fault_clear();
        plan.delete();
        add_restart();
        add_norm(2'b00, 2'b11, 2);
        add(2'b00, 2'b00, 1'b0, 1'b1, ew(R, R, 1'b1, 3'd1));
        // later illegal codes must not overwrite the latched cause
        for (int i = 1; i <= 3; i++) add(2'b10, 2'b11, 1'b0, 1'b1, ew(R, R, 1'b1, 3'd1));
        add_flash(3'd1, 4, 10);
        // clear during the off half
        add(2'b10, 2'b00, 1'b1, 1'b1, ew(R, R, 1'b0, 3'd0));
        // first sample after clear is yellow: no transition check, and it counts as one yellow
        add_norm(2'b01, 2'b11, MIN_YELLOW);
        add_norm(2'b11, 2'b11, 1);
        // clear outside FAULT is ignored
        add(2'b11, 2'b00, 1'b1, 1'b1, ew(R, G, 1'b0, 3'd0));
        add_norm(2'b11, 2'b00, 2);
        // second fault: flash phase restarts with an on half
        add(2'b00, 2'b00, 1'b0, 1'b1, ew(R, R, 1'b1, 3'd1));
        add_flash(3'd1, 1, 9);
        for (int k = 0; k < plan.size(); k++) begin
            logic [9:0] got, want;
            drive_step(plan[k]);
            want = sb.pop_front();
            got  = {highway_lamps, farm_lamps, fault, fault_code};
            checks++;
            if (got !== want) begin
                errors++;
                $display("FAIL fault_clear[%0d]: got lamps=%b/%b fault=%b code=%0d, want lamps=%b/%b fault=%b code=%0d",
                         k, got[9:7], got[6:4], got[3], got[2:0], want[9:7], want[6:4], want[3], want[2:0]);
            end
        end
    endtask

    task automatic test_reset_mid_fault();
        plan.delete();
        add_restart();
        add_norm(2'b00, 2'b11, 2);
        add(2'b00, 2'b00, 1'b0, 1'b1, ew(R, R, 1'b1, 3'd1));
        add_flash(3'd1, 1, 9);
        // reset in the off half, with a simultaneous clear and conflicting inputs
        add(2'b00, 2'b00, 1'b1, 1'b0, ew(R, R, 1'b0, 3'd0));
        add(2'b11, 2'b11, 1'b0, 1'b1, ew(R, R, 1'b0, 3'd0));
        add(2'b11, 2'b11, 1'b0, 1'b1, ew(R, R, 1'b0, 3'd0));
        add_norm(2'b00, 2'b11, 2);
        add_norm(2'b01, 2'b11, 1);
        for (int k = 0; k < plan.size(); k++) begin
            logic [9:0] got, want;
            drive_step(plan[k]);
            want = sb.pop_front();
            got  = {highway_lamps, farm_lamps, fault, fault_code};
            checks++;
            if (got !== want) begin
                errors++;
                $display("FAIL reset_mid_fault[%0d]: got lamps=%b/%b fault=%b code=%0d, want lamps=%b/%b fault=%b code=%0d",
                         k, got[9:7], got[6:4], got[3], got[2:0], want[9:7], want[6:4], want[3], want[2:0]);
            end
        end
    endtask

    initial begin
        rst_n         = 1'b0;
        fault_clear   = 1'b0;
        highway_light = 2'b11;
        farm_light    = 2'b11;
        test_reset();
        test_normal();
        test_conflict();
        test_illegal();
        test_short_yellow();
        test_fault_clear();
        test_reset_mid_fault();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete within time limit");
        $fatal(1, "timeout");
    end

endmodule
